// File: rtl/enchimento_pkg.sv
// Shared definitions for the bottle filling line.
// Holds the filling FSM state codes so the sealing stage and the top level
// can decode the same encoding, plus a small helper for sizing timers.
package enchimento_pkg;

  // 3-bit state encoding; code 3'd7 is unused and recovers to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ALIGN   = 3'd1,
    ST_FILL    = 3'd2,
    ST_DRIP    = 3'd3,
    ST_DONE    = 3'd4,
    ST_RELEASE = 3'd5,
    ST_ALARM   = 3'd6
  } state_t;

  // Bits needed to hold any count in 0..max(a,b) (at least 1 bit).
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/saida_enchimento.sv
// Output decoder for the filling FSM (pure Moore decode of the state).
// Ports:
//   state  - current FSM state
//   motor  - conveyor run
//   ev     - fill valve open
//   done   - bottle filled pulse
//   alarme - alarm active
module saida_enchimento
  import enchimento_pkg::*;
(
  input  state_t state,
  output logic   motor,
  output logic   ev,
  output logic   done,
  output logic   alarme
);

  always_comb begin
    motor  = 1'b0;
    ev     = 1'b0;
    done   = 1'b0;
    alarme = 1'b0;
    case (state)
      ST_IDLE:    motor  = 1'b1;
      ST_ALIGN:   motor  = 1'b1;
      ST_FILL:    ev     = 1'b1;
      ST_DRIP:    ;
      ST_DONE:    done   = 1'b1;
      ST_RELEASE: motor  = 1'b1;
      ST_ALARM:   alarme = 1'b1;
      // Unused code behaves like IDLE until the register recovers.
      default:    motor  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mef_enchimento.sv
// Bottle filling station controller.
// Moves a bottle under the nozzle, opens the valve until the level sensor
// trips (or a timeout raises the alarm), waits for drips, pulses done and
// counts the filled bottle, then releases it down the conveyor.
// Ports:
//   clk, reset    - clock (rising edge), asynchronous active-high reset
//   garrafa       - bottle present in filling zone
//   pos           - bottle aligned under nozzle
//   nivel         - level sensor, bottle full
//   reservatorio  - supply tank not empty
//   ack           - operator alarm acknowledge
//   motor, ev, done, alarme - decoded state outputs
//   total         - saturating count of filled bottles
module mef_enchimento
  import enchimento_pkg::*;
#(
  parameter int TIMEOUT = 200,
  parameter int DRIP    = 10,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          garrafa,
  input  logic          pos,
  input  logic          nivel,
  input  logic          reservatorio,
  input  logic          ack,
  output logic          motor,
  output logic          ev,
  output logic          done,
  output logic          alarme,
  output logic [CW-1:0] total
);

  localparam int TW = timer_width(TIMEOUT, DRIP);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] DRIP_LAST    = TW'(DRIP - 1);

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg;
  logic [CW-1:0]   total_reg;

  // Next-state logic. A missing supply tank pre-empts everything else
  // while the bottle is being positioned or filled.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!reservatorio)  state_next = ST_ALARM;
        else if (garrafa)   state_next = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (!reservatorio)  state_next = ST_ALARM;
        else if (pos)       state_next = ST_FILL;
        else if (!garrafa)  state_next = ST_IDLE;
      end
      ST_FILL: begin
        if (!reservatorio)                    state_next = ST_ALARM;
        else if (nivel)                       state_next = ST_DRIP;
        else if (timer_reg == TIMEOUT_LAST)   state_next = ST_ALARM;
      end
      ST_DRIP: begin
        if (timer_reg == DRIP_LAST) state_next = ST_DONE;
      end
      ST_DONE:    state_next = ST_RELEASE;
      ST_RELEASE: begin
        if (!garrafa) state_next = ST_IDLE;
      end
      ST_ALARM: begin
        if (ack && reservatorio) state_next = ST_IDLE;
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Timer restarts from zero on every state change and only runs in the
  // timed states, so it never needs more range than the longest interval.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_reg <= '0;
    end else if (state_next != state_reg) begin
      timer_reg <= '0;
    end else if (state_reg == ST_FILL || state_reg == ST_DRIP) begin
      timer_reg <= timer_reg + TW'(1);
    end
  end

  // Count the bottle on entry to DONE so the new total is visible while
  // done is high; saturate at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_reg <= '0;
    end else if (state_reg == ST_DRIP && state_next == ST_DONE && total_reg != '1) begin
      total_reg <= total_reg + CW'(1);
    end
  end

  assign total = total_reg;

  saida_enchimento u_saida (
    .state  (state_reg),
    .motor  (motor),
    .ev     (ev),
    .done   (done),
    .alarme (alarme)
  );

endmodule

// File: tb/tb_mef_enchimento.sv
// Directed bench for mef_enchimento. Filled-bottle totals are predicted when
// a bottle is fed in and checked against the DUT when done pulses.
module tb_mef_enchimento;

  localparam int CW      = 2;
  localparam int TIMEOUT = 200;
  localparam int DRIP    = 10;
  localparam logic [CW-1:0] TOTAL_MAX = '1;

  logic          clk = 1'b0;
  logic          reset;
  logic          garrafa, pos, nivel, reservatorio, ack;
  logic          motor, ev, done, alarme;
  logic [CW-1:0] total;

  int compared   = 0;
  int mismatched = 0;
  int done_count = 0;
  int ev_count   = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] exp_total;

  always #5 clk = ~clk;

  mef_enchimento #(.TIMEOUT(TIMEOUT), .DRIP(DRIP), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .garrafa      (garrafa),
    .pos          (pos),
    .nivel        (nivel),
    .reservatorio (reservatorio),
    .ack          (ack),
    .motor        (motor),
    .ev           (ev),
    .done         (done),
    .alarme       (alarme),
    .total        (total)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every done pulse must match a predicted bottle.
  always @(negedge clk) begin
    if (ev === 1'b1) ev_count++;
    if (done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [CW-1:0] e;
        e = exp_q.pop_front();
        check("done_total", 32'(total), 32'(e));
        $display("bottle done: total=%0d expected=%0d", total, e);
      end
    end
  end

  function automatic logic [CW-1:0] next_total(input logic [CW-1:0] t);
    return (t == TOTAL_MAX) ? t : t + 1'b1;
  endfunction

  // Feed one bottle straight into FILL (two edges: IDLE->ALIGN->FILL).
  task automatic enter_fill();
    garrafa = 1'b1;
    pos     = 1'b1;
    tick();
    tick();
    pos = 1'b0;
  endtask

  int ev_base, done_base;
  bit seen;

  initial begin
    reset = 1'b1; garrafa = 1'b0; pos = 1'b0; nivel = 1'b0;
    reservatorio = 1'b1; ack = 1'b0;
    exp_total = '0;
    tick(); tick();
    check("rst_motor", 32'(motor), 32'd1);
    check("rst_ev", 32'(ev), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_alarme", 32'(alarme), 32'd0);
    check("rst_total", 32'(total), 32'd0);
    reset = 1'b0;
    tick();
    $display("reset released");

    // Normal fill: pos after 3 cycles, level after 50 FILL cycles.
    garrafa = 1'b1;
    exp_total = next_total(exp_total);
    exp_q.push_back(exp_total);
    tick(); tick(); tick();
    check("align_motor", 32'(motor), 32'd1);
    pos = 1'b1;
    ev_base = ev_count;
    tick();
    pos = 1'b0;
    check("fill_ev", 32'(ev), 32'd1);
    check("fill_motor", 32'(motor), 32'd0);
    repeat (49) tick();
    nivel = 1'b1;
    tick();
    nivel = 1'b0;
    check("normal_ev_cycles", 32'(ev_count - ev_base), 32'd50);
    check("drip_ev", 32'(ev), 32'd0);
    repeat (DRIP - 1) tick();
    check("drip_last_done", 32'(done), 32'd0);
    tick();
    check("done_pulse", 32'(done), 32'd1);
    check("done_total_now", 32'(total), 32'(exp_total));
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("release_motor", 32'(motor), 32'd1);
    garrafa = 1'b0;
    tick();
    check("normal_done_count", 32'(done_count), 32'd1);
    $display("normal fill complete");

    // Timeout: level never arrives.
    ev_base = ev_count;
    enter_fill();
    garrafa = 1'b0;
    repeat (TIMEOUT - 1) tick();
    check("timeout_last_ev", 32'(ev), 32'd1);
    check("timeout_last_alarme", 32'(alarme), 32'd0);
    tick();
    check("timeout_alarme", 32'(alarme), 32'd1);
    check("timeout_ev", 32'(ev), 32'd0);
    check("timeout_motor", 32'(motor), 32'd0);
    check("timeout_ev_cycles", 32'(ev_count - ev_base), 32'(TIMEOUT));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("timeout_ack_idle", 32'(alarme), 32'd0);
    check("timeout_total", 32'(total), 32'(exp_total));
    $display("timeout handled");

    // Tank empties at FILL cycle 20; ack is ignored until it refills.
    enter_fill();
    garrafa = 1'b0;
    repeat (19) tick();
    reservatorio = 1'b0;
    tick();
    check("tank_alarme", 32'(alarme), 32'd1);
    check("tank_ev", 32'(ev), 32'd0);
    ack = 1'b1;
    tick(); tick();
    check("tank_ack_held", 32'(alarme), 32'd1);
    reservatorio = 1'b1;
    tick();
    ack = 1'b0;
    check("tank_recover", 32'(alarme), 32'd0);
    $display("tank empty handled");

    // Reset in the middle of FILL acts without waiting for a clock edge.
    enter_fill();
    repeat (29) tick();
    check("prereset_ev", 32'(ev), 32'd1);
    reset = 1'b1;
    #1;
    exp_total = '0;
    check("async_rst_ev", 32'(ev), 32'd0);
    check("async_rst_motor", 32'(motor), 32'd1);
    check("async_rst_total", 32'(total), 32'd0);
    garrafa = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_idle", 32'(motor), 32'd1);
    $display("reset mid-fill handled");

    // Level and empty tank together: alarm wins, no bottle counted.
    done_base = done_count;
    enter_fill();
    garrafa = 1'b0;
    repeat (4) tick();
    nivel = 1'b1;
    reservatorio = 1'b0;
    tick();
    nivel = 1'b0;
    check("simul_alarme", 32'(alarme), 32'd1);
    reservatorio = 1'b1;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (DRIP + 2) tick();
    check("simul_no_done", 32'(done_count - done_base), 32'd0);
    check("simul_total", 32'(total), 32'(exp_total));
    $display("simultaneous level/tank handled");

    // Five quick bottles: a 2-bit count stops at 3.
    for (int b = 0; b < 5; b++) begin
      exp_total = next_total(exp_total);
      exp_q.push_back(exp_total);
      enter_fill();
      nivel = 1'b1;
      tick();
      nivel = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
        tick();
        if (done === 1'b1) seen = 1'b1;
      end
      check("sat_done_seen", 32'(seen), 32'd1);
      tick();
      garrafa = 1'b0;
      tick();
      check("sat_total", 32'(total), 32'(exp_total));
      $display("saturation bottle %0d: total=%0d expected=%0d", b, total, exp_total);
    end
    check("sat_final", 32'(total), 32'd3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mef_enchimento.md
MEF_ENCHIMENTO -- requirements
Module: mef_enchimento

Interface
REQ-001 SHALL have parameter TIMEOUT, default 200, max clock cycles the valve may stay open before the alarm.
REQ-002 SHALL have parameter DRIP, default 10, cycles the valve stays closed after level reached, before release.
REQ-003 SHALL have parameter CW, default 8, width of the filled-bottle counter.
REQ-004 clk  input  1  system clock, rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 garrafa  input  1  bottle present in filling zone.
REQ-007 pos  input  1  bottle aligned under nozzle.
REQ-008 nivel  input  1  level sensor, bottle full.
REQ-009 reservatorio  input  1  supply tank not empty.
REQ-010 ack  input  1  operator alarm acknowledge.
REQ-011 motor  output  1  conveyor run.
REQ-012 ev  output  1  fill valve open.
REQ-013 done  output  1  one-cycle pulse: bottle filled, handed to sealing stage.
REQ-014 alarme  output  1  alarm active.
REQ-015 total  output  CW  count of bottles filled.

Function
REQ-016 SHALL implement Moore FSM: IDLE, ALIGN, FILL, DRIP, DONE, RELEASE, ALARM (3-bit encoding); unused codes -> IDLE.
REQ-017 IDLE: motor=1; garrafa=1 -> ALIGN.
REQ-018 ALIGN: motor=1; pos=1 -> FILL; garrafa=0 -> IDLE.
REQ-019 FILL: motor=0, ev=1; timer counts cycles from 0 on entry; nivel=1 -> DRIP; timer==TIMEOUT-1 with nivel=0 -> ALARM.
REQ-020 In IDLE, ALIGN, FILL: reservatorio=0 -> ALARM, priority over all other transitions.
REQ-021 DRIP: motor=0, ev=0; timer restarts at 0; timer==DRIP-1 -> DONE.
REQ-022 DONE: exactly one cycle, done=1, motor=0; total increments, saturating at 2^CW-1; -> RELEASE unconditionally.
REQ-023 RELEASE: motor=1; garrafa=0 -> IDLE.
REQ-024 ALARM: alarme=1, motor=0, ev=0; ack=1 and reservatorio=1 -> IDLE; total unchanged.
REQ-025 Outputs decoded from state only; ev=1 only in FILL; done=1 only in DONE; alarme=1 only in ALARM.
REQ-026 Timer SHALL be wide enough for max(TIMEOUT,DRIP) and clear on every state change.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, timer=0, total=0, ev=0, done=0, alarme=0, motor=1 (IDLE decode), including mid-FILL.

Structure
REQ-028 State codes SHALL reside in shared package/include enchimento_pkg, also consumable by the sealing stage and top-level.
REQ-029 Output decoding SHALL be one sub-module saida_enchimento (state in, motor/ev/done/alarme out).

Verification
REQ-030 Normal: garrafa=1, pos=1 after 3 cycles, nivel=1 after 50 cycles in FILL -> ev high 50 cycles, 10 DRIP cycles, done single pulse, total=1.
REQ-031 Timeout: nivel held 0 -> ALARM after exactly 200 FILL cycles, ev=0, alarme=1; ack with reservatorio=1 -> IDLE, total=0.
REQ-032 Tank empty: reservatorio=0 at FILL cycle 20 -> ALARM next cycle; ack=1 with reservatorio=0 -> stays ALARM.
REQ-033 Reset mid-FILL at cycle 30 -> ev=0, total=0, motor=1 immediately, FSM in IDLE.
REQ-034 Saturation: CW=2, 5 bottles -> total stops at 3.
REQ-035 Simultaneous: nivel=1 and reservatorio=0 same FILL cycle -> ALARM, no done.
